// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle N-bit add/subtract, W bits per clock with a registered inter-chunk carry
module seq_chunk_adder #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         busy,
  output logic         done
);
  localparam int K  = N / W;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  if (W < 1 || W > N || N % W != 0) begin : g_chk
    $error("seq_chunk_adder: N must be a multiple of W with 1 <= W <= N");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] a_r, b_r, res, res_n;
  logic [IW-1:0] idx;
  logic cy_r, sub_r, cy, last;
  logic [W-1:0] a_ch, b_ch, part;
  assign a_ch = a_r[idx*W +: W];
  assign b_ch = b_r[idx*W +: W];
  assign {cy, part} = {1'b0, a_ch} + {1'b0, b_ch} + (W+1)'(cy_r);
  assign last = idx == IW'(K - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    res_n = res;
    res_n[idx*W +: W] = part;
  end
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  // subtraction is A + ~B + ~c, so the stored carry and final carry are inverted for borrow
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      idx   <= '0;
      cy_r  <= 1'b0;
      sub_r <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_r   <= A;
        b_r   <= mode ? ~B : B;
        cy_r  <= c ^ mode;
        sub_r <= mode;
        idx   <= '0;
      end
      if (state == RUN) begin
        res  <= res_n;
        cy_r <= cy;
        idx  <= last ? '0 : idx + 1'b1;
      end
      if (state == RUN && last) begin
        sum   <= res_n;
        c_out <= cy ^ sub_r;
        ovf   <= (a_ch[W-1] == b_ch[W-1]) && (part[W-1] != a_ch[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: table vectors and corner sequences on N=8/W=4, plus a random N=32 sweep over W
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, mode, c;
  logic [7:0] a, b, sum;
  logic c_out, ovf, busy, done;
  seq_chunk_adder #(.N(8), .W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .A(a), .B(b), .c(c),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done)
  );
  logic xstart, xm, xc;
  logic [31:0] xa, xb;
  logic [31:0] xs [3];
  logic xco [3], xov [3], xbusy [3], xdone [3];
  for (genvar g = 0; g < 3; g++) begin : g_sw
    seq_chunk_adder #(.N(32), .W(g == 0 ? 1 : g == 1 ? 8 : 32)) u (
      .clk(clk), .rst(rst), .start(xstart), .mode(xm), .A(xa), .B(xb), .c(xc),
      .sum(xs[g]), .c_out(xco[g]), .ovf(xov[g]), .busy(xbusy[g]), .done(xdone[g])
    );
  end
  typedef struct {logic [7:0] s; logic co, ov;} res8_t;
  typedef struct {logic m; logic [7:0] a, b; logic c; logic [7:0] s; logic co, ov;} vec_t;
  typedef struct {logic [31:0] s; logic co, ov; int t;} r32_t;
  res8_t q8[$];
  r32_t q32[$];
  res8_t e8;
  vec_t tv[10];
  int kk[3] = '{32, 4, 1};
  int total = 0, bad = 0, cyc = 0;
  logic [2:0] pend;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (q8.size() == 0) chk("done8_extra", done, 0);
      else begin
        e8 = q8.pop_front();
        chk("result8", {sum, c_out, ovf}, {e8.s, e8.co, e8.ov});
      end
    end
    for (int g = 0; g < 3; g++)
      if (xdone[g]) begin
        chk("sweep_pending", pend[g] && q32.size() != 0, 1);
        if (pend[g] && q32.size() != 0) begin
          chk("sweep_result", {xs[g], xco[g], xov[g]}, {q32[0].s, q32[0].co, q32[0].ov});
          chk("sweep_latency", cyc - q32[0].t, kk[g] + 1);
          pend[g] = 1'b0;
        end
      end
  end
  task automatic drive8(input logic m, input logic [7:0] aa, bb, input logic cc);
    @(negedge clk);
    mode = m; a = aa; b = bb; c = cc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic op8(input logic m, input logic [7:0] aa, bb, input logic cc,
                     input logic [7:0] s, input logic co, ov);
    int bc;
    bit seen;
    q8.push_back('{s, co, ov});
    drive8(m, aa, bb, cc);
    bc = int'(busy);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
      else bc += int'(busy);
    end
    chk("done8_seen", seen, 1);
    chk("busy8_cycles", bc, 2);
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [32:0] full;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; c = 1'b0;
    xstart = 1'b0; xm = 1'b0; xa = '0; xb = '0; xc = 1'b0; pend = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset8", {sum, c_out, ovf, busy, done}, 0);
    for (int g = 0; g < 3; g++) chk("reset32", {xs[g], xco[g], xov[g], xbusy[g], xdone[g]}, 0);
    tv[0] = '{1'b0, 8'hCA, 8'hAE, 1'b0, 8'h78, 1'b1, 1'b1};
    tv[1] = '{1'b1, 8'hCA, 8'hAE, 1'b0, 8'h1C, 1'b0, 1'b0};
    tv[2] = '{1'b1, 8'hCA, 8'hAE, 1'b1, 8'h1B, 1'b0, 1'b0};
    tv[3] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[5] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tv[6] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tv[7] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
    tv[8] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[9] = '{1'b0, 8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) op8(tv[i].m, tv[i].a, tv[i].b, tv[i].c, tv[i].s, tv[i].co, tv[i].ov);
    // start while busy and start during DONE must both be dropped
    q8.push_back('{8'h02, 1'b0, 1'b0});
    drive8(1'b0, 8'h01, 8'h01, 1'b0);
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("done_state", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("ignored_no_busy", busy, 0);
    chk("sum_held", sum, 8'h02);
    // reset one edge into RUN aborts with no done
    drive8(1'b0, 8'h33, 8'h44, 1'b0);
    @(negedge clk);
    chk("busy_in_run", busy, 1);
    chk("sum_hold_run", sum, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {sum, c_out, ovf, busy, done}, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_busy", busy, 0);
    op8(1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      case (i)
        0: begin xm = 1'b0; xa = 32'hFFFF_FFFF; xb = 32'h0; xc = 1'b1; end
        1: begin xm = 1'b0; xa = 32'h7FFF_FFFF; xb = 32'h1; xc = 1'b0; end
        2: begin xm = 1'b1; xa = 32'h8000_0000; xb = 32'h1; xc = 1'b0; end
        3: begin xm = 1'b1; xa = 32'h0; xb = 32'h0; xc = 1'b1; end
        default: begin xm = 1'($urandom); xa = $urandom; xb = $urandom; xc = 1'($urandom); end
      endcase
      full = xm ? {1'b0, xa} - {1'b0, xb} - 33'(xc) : {1'b0, xa} + {1'b0, xb} + 33'(xc);
      q32.push_back('{full[31:0], full[32],
        xm ? (xa[31] != xb[31] && full[31] != xa[31]) : (xa[31] == xb[31] && full[31] != xa[31]), cyc});
      pend = 3'b111;
      xstart = 1'b1;
      @(negedge clk);
      xstart = 1'b0;
      for (int n = 0; n < 60 && pend != 0; n++) begin
        @(posedge clk);
        #2;
      end
      chk("sweep_timeout", pend, 0);
      pend = '0;
      void'(q32.pop_front());
      @(posedge clk);
    end
    chk("q8_empty_end", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
